// File: rtl/l1_tag_update_ctrl.sv
// L1 tag-array update sequencer. Buffers L2 fill / invalidate / flush-all
// responses in a small FIFO and issues at most one registered tag/valid write
// per cycle. A flush-all is expanded into a back-to-back sweep that clears
// every way of every set, followed by a one-cycle completion pulse.
module l1_tag_update_ctrl #(
   parameter int SET_INDEX_WIDTH = 5,
   parameter int TAG_WIDTH       = 21,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       resp_valid,
   output logic                       resp_ready,
   input  logic [1:0]                 resp_op,
   input  logic [1:0]                 resp_way,
   input  logic [25:0]                resp_addr,
   output logic                       update_o,
   output logic                       invalidate_one_way_o,
   output logic                       invalidate_all_ways_o,
   output logic [1:0]                 update_way_o,
   output logic [TAG_WIDTH-1:0]       update_tag_o,
   output logic [SET_INDEX_WIDTH-1:0] update_set_o,
   output logic                       flush_busy_o,
   output logic                       flush_done_o
);

   localparam int NUM_SETS = 2 ** SET_INDEX_WIDTH;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;

   localparam logic [1:0] OP_FILL  = 2'd0;
   localparam logic [1:0] OP_INV   = 2'd1;
   localparam logic [1:0] OP_FLUSH = 2'd2;

   // DONE is a dedicated cycle so the completion pulse never shares a cycle
   // with the first write popped after the sweep.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t state, state_d;

   // Response buffer
   logic [1:0]  op_mem   [FIFO_DEPTH];
   logic [1:0]  way_mem  [FIFO_DEPTH];
   logic [25:0] addr_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic fifo_full, fifo_empty, push, pop;

   logic [1:0]  head_op, head_way;
   logic [25:0] head_addr;

   logic [SET_INDEX_WIDTH-1:0] sweep_cnt, sweep_cnt_d;

   logic                       update_d, inv_one_d, inv_all_d, busy_d, done_d;
   logic [1:0]                 way_d;
   logic [TAG_WIDTH-1:0]       tag_d;
   logic [SET_INDEX_WIDTH-1:0] set_d;

   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign resp_ready = !fifo_full;
   assign push       = resp_valid && !fifo_full;
   // Pops only happen in IDLE; the sweep and its completion cycle stall the queue.
   assign pop        = (state == ST_IDLE) && !fifo_empty;

   assign head_op   = op_mem[rd_ptr];
   assign head_way  = way_mem[rd_ptr];
   assign head_addr = addr_mem[rd_ptr];

   // Buffer storage: written on accept, no reset needed since occupancy guards reads
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr]   <= resp_op;
         way_mem[wr_ptr]  <= resp_way;
         addr_mem[wr_ptr] <= resp_addr;
      end
   end

   // Buffer pointers and occupancy; push and pop may coincide
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Next-state and next-output decode; unchanged fields hold their last value
   always_comb begin
      state_d     = state;
      sweep_cnt_d = sweep_cnt;
      update_d    = 1'b0;
      inv_one_d   = 1'b0;
      inv_all_d   = 1'b0;
      done_d      = 1'b0;
      busy_d      = flush_busy_o;
      way_d       = update_way_o;
      tag_d       = update_tag_o;
      set_d       = update_set_o;
      case (state)
         ST_IDLE: begin
            if (pop) begin
               case (head_op)
                  OP_FILL: begin
                     update_d = 1'b1;
                     way_d    = head_way;
                     tag_d    = head_addr[25:SET_INDEX_WIDTH];
                     set_d    = head_addr[SET_INDEX_WIDTH-1:0];
                  end
                  OP_INV: begin
                     inv_one_d = 1'b1;
                     way_d     = head_way;
                     set_d     = head_addr[SET_INDEX_WIDTH-1:0];
                  end
                  OP_FLUSH: begin
                     state_d     = ST_SWEEP;
                     sweep_cnt_d = '0;
                     busy_d      = 1'b1;
                  end
                  default: begin
                     // reserved op: dropped silently
                  end
               endcase
            end
         end
         ST_SWEEP: begin
            inv_all_d = 1'b1;
            set_d     = sweep_cnt;
            if (sweep_cnt == SET_INDEX_WIDTH'(NUM_SETS - 1)) begin
               state_d     = ST_DONE;
               sweep_cnt_d = '0;
            end else begin
               sweep_cnt_d = sweep_cnt + SET_INDEX_WIDTH'(1);
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, sweep counter and registered update port
   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= ST_IDLE;
         sweep_cnt             <= '0;
         update_o              <= 1'b0;
         invalidate_one_way_o  <= 1'b0;
         invalidate_all_ways_o <= 1'b0;
         flush_busy_o          <= 1'b0;
         flush_done_o          <= 1'b0;
         update_way_o          <= '0;
         update_tag_o          <= '0;
         update_set_o          <= '0;
      end else begin
         state                 <= state_d;
         sweep_cnt             <= sweep_cnt_d;
         update_o              <= update_d;
         invalidate_one_way_o  <= inv_one_d;
         invalidate_all_ways_o <= inv_all_d;
         flush_busy_o          <= busy_d;
         flush_done_o          <= done_d;
         update_way_o          <= way_d;
         update_tag_o          <= tag_d;
         update_set_o          <= set_d;
      end
   end

endmodule

// File: tb/tb_l1_tag_update_ctrl.sv
// Directed bench for l1_tag_update_ctrl: reset/idle, single fill, mixed
// ordering, flush sweep with queued fill, FIFO back-pressure during a sweep,
// and reset in the middle of a sweep.
module tb_l1_tag_update_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_op;
   logic [1:0]  resp_way;
   logic [25:0] resp_addr;
   logic        update_o;
   logic        invalidate_one_way_o;
   logic        invalidate_all_ways_o;
   logic [1:0]  update_way_o;
   logic [20:0] update_tag_o;
   logic [4:0]  update_set_o;
   logic        flush_busy_o;
   logic        flush_done_o;

   int checks   = 0;
   int failures = 0;
   logic mon_en = 1'b0;

   l1_tag_update_ctrl #(
      .SET_INDEX_WIDTH(5),
      .TAG_WIDTH(21),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_op(resp_op),
      .resp_way(resp_way),
      .resp_addr(resp_addr),
      .update_o(update_o),
      .invalidate_one_way_o(invalidate_one_way_o),
      .invalidate_all_ways_o(invalidate_all_ways_o),
      .update_way_o(update_way_o),
      .update_tag_o(update_tag_o),
      .update_set_o(update_set_o),
      .flush_busy_o(flush_busy_o),
      .flush_done_o(flush_done_o)
   );

   always #5 clk = ~clk;

   // At most one write pulse may be high in any cycle
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         assert ($countones({update_o, invalidate_one_way_o, invalidate_all_ways_o}) <= 1)
         else begin
            failures++;
            $error("FAIL mutex observed=%b expected=at most one high",
                   {update_o, invalidate_one_way_o, invalidate_all_ways_o});
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] way,
                        input logic [25:0] addr);
      resp_valid = v;
      resp_op    = op;
      resp_way   = way;
      resp_addr  = addr;
   endtask

   function automatic logic [25:0] mk_addr(input logic [20:0] tag, input logic [4:0] set);
      return {tag, set};
   endfunction

   // {update, inv_one, inv_all, done}
   function automatic logic [31:0] pulses();
      return {28'd0, update_o, invalidate_one_way_o, invalidate_all_ways_o, flush_done_o};
   endfunction

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'd0, 2'd0, 26'd0);
      step();
      step();
      reset = 1'b0;
      mon_en = 1'b1;

      // Reset state
      chk("rst_pulses", pulses(), 32'h0);
      chk("rst_busy", {31'd0, flush_busy_o}, 32'd0);
      chk("rst_ready", {31'd0, resp_ready}, 32'd1);
      chk("rst_way", {30'd0, update_way_o}, 32'd0);
      chk("rst_tag", {11'd0, update_tag_o}, 32'd0);
      chk("rst_set", {27'd0, update_set_o}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_pulses", pulses(), 32'h0);
         chk("idle_ready", {31'd0, resp_ready}, 32'd1);
      end

      // Single FILL: way 2, addr 0ABCDE5 -> set 5, tag 055E6F
      drive(1'b1, 2'd0, 2'd2, 26'h0ABCDE5);
      step();
      drive(1'b0, 2'd0, 2'd0, 26'd0);
      chk("fill1_early", pulses(), 32'h0);
      step();
      chk("fill1_pulse", pulses(), 32'h8);
      chk("fill1_way", {30'd0, update_way_o}, 32'd2);
      chk("fill1_set", {27'd0, update_set_o}, 32'd5);
      chk("fill1_tag", {11'd0, update_tag_o}, 32'h055E6F);
      step();
      chk("fill1_end", pulses(), 32'h0);

      // FILL / INVALIDATE / FILL in order; INVALIDATE keeps the old tag
      drive(1'b1, 2'd0, 2'd0, mk_addr(21'h001234, 5'd3));
      step();
      drive(1'b1, 2'd1, 2'd1, mk_addr(21'h000777, 5'd3));
      step();
      chk("seq_a_pulse", pulses(), 32'h8);
      chk("seq_a_way", {30'd0, update_way_o}, 32'd0);
      chk("seq_a_set", {27'd0, update_set_o}, 32'd3);
      chk("seq_a_tag", {11'd0, update_tag_o}, 32'h001234);
      drive(1'b1, 2'd0, 2'd3, mk_addr(21'h00ABCD, 5'd7));
      step();
      drive(1'b0, 2'd0, 2'd0, 26'd0);
      chk("seq_b_pulse", pulses(), 32'h4);
      chk("seq_b_way", {30'd0, update_way_o}, 32'd1);
      chk("seq_b_set", {27'd0, update_set_o}, 32'd3);
      chk("seq_b_tag_held", {11'd0, update_tag_o}, 32'h001234);
      step();
      chk("seq_c_pulse", pulses(), 32'h8);
      chk("seq_c_way", {30'd0, update_way_o}, 32'd3);
      chk("seq_c_set", {27'd0, update_set_o}, 32'd7);
      chk("seq_c_tag", {11'd0, update_tag_o}, 32'h00ABCD);
      step();
      chk("seq_end", pulses(), 32'h0);

      // FLUSH_ALL with a FILL queued behind it
      drive(1'b1, 2'd2, 2'd0, 26'd0);
      step();
      drive(1'b1, 2'd0, 2'd1, mk_addr(21'h002222, 5'd9));
      step();
      drive(1'b0, 2'd0, 2'd0, 26'd0);
      chk("fl_start_busy", {31'd0, flush_busy_o}, 32'd1);
      chk("fl_start_pulses", pulses(), 32'h0);
      for (int i = 0; i < 32; i++) begin
         step();
         chk("fl_sweep_pulse", pulses(), 32'h2);
         chk("fl_sweep_set", {27'd0, update_set_o}, i);
         chk("fl_sweep_busy", {31'd0, flush_busy_o}, 32'd1);
      end
      step();
      chk("fl_done_pulse", pulses(), 32'h1);
      chk("fl_done_busy", {31'd0, flush_busy_o}, 32'd0);
      step();
      chk("fl_fill_pulse", pulses(), 32'h8);
      chk("fl_fill_way", {30'd0, update_way_o}, 32'd1);
      chk("fl_fill_set", {27'd0, update_set_o}, 32'd9);
      chk("fl_fill_tag", {11'd0, update_tag_o}, 32'h002222);
      step();
      chk("fl_end", pulses(), 32'h0);

      // Back-pressure: fill the FIFO during a sweep, hold a 5th entry
      drive(1'b1, 2'd2, 2'd0, 26'd0);
      step();
      drive(1'b1, 2'd0, 2'd0, mk_addr(21'h000011, 5'd1));
      step();
      drive(1'b1, 2'd1, 2'd1, mk_addr(21'h000099, 5'd2));
      step();
      drive(1'b1, 2'd0, 2'd2, mk_addr(21'h000033, 5'd3));
      step();
      chk("bp_ready_3", {31'd0, resp_ready}, 32'd1);
      drive(1'b1, 2'd0, 2'd3, mk_addr(21'h000044, 5'd4));
      step();
      chk("bp_full_ready", {31'd0, resp_ready}, 32'd0);
      chk("bp_sweep_set2", {27'd0, update_set_o}, 32'd2);
      drive(1'b1, 2'd1, 2'd2, mk_addr(21'h000055, 5'd5));
      for (int i = 3; i < 32; i++) begin
         step();
         chk("bp_sweep_pulse", pulses(), 32'h2);
         chk("bp_sweep_set", {27'd0, update_set_o}, i);
         chk("bp_sweep_ready", {31'd0, resp_ready}, 32'd0);
      end
      step();
      chk("bp_done", pulses(), 32'h1);
      chk("bp_done_ready", {31'd0, resp_ready}, 32'd0);
      step();
      chk("bp_a_pulse", pulses(), 32'h8);
      chk("bp_a_set", {27'd0, update_set_o}, 32'd1);
      chk("bp_a_tag", {11'd0, update_tag_o}, 32'h000011);
      chk("bp_a_ready", {31'd0, resp_ready}, 32'd1);
      step();
      drive(1'b0, 2'd0, 2'd0, 26'd0);
      chk("bp_b_pulse", pulses(), 32'h4);
      chk("bp_b_way", {30'd0, update_way_o}, 32'd1);
      chk("bp_b_set", {27'd0, update_set_o}, 32'd2);
      step();
      chk("bp_c_pulse", pulses(), 32'h8);
      chk("bp_c_way", {30'd0, update_way_o}, 32'd2);
      chk("bp_c_tag", {11'd0, update_tag_o}, 32'h000033);
      step();
      chk("bp_d_pulse", pulses(), 32'h8);
      chk("bp_d_way", {30'd0, update_way_o}, 32'd3);
      chk("bp_d_set", {27'd0, update_set_o}, 32'd4);
      chk("bp_d_tag", {11'd0, update_tag_o}, 32'h000044);
      step();
      chk("bp_e_pulse", pulses(), 32'h4);
      chk("bp_e_way", {30'd0, update_way_o}, 32'd2);
      chk("bp_e_set", {27'd0, update_set_o}, 32'd5);
      chk("bp_e_tag_held", {11'd0, update_tag_o}, 32'h000044);
      step();
      chk("bp_end", pulses(), 32'h0);

      // Reset at sweep set 10 with a FILL queued behind the flush
      drive(1'b1, 2'd2, 2'd0, 26'd0);
      step();
      drive(1'b1, 2'd0, 2'd1, mk_addr(21'h003333, 5'd6));
      step();
      drive(1'b0, 2'd0, 2'd0, 26'd0);
      for (int i = 0; i < 11; i++) step();
      chk("mr_set10", {27'd0, update_set_o}, 32'd10);
      chk("mr_set10_pulse", pulses(), 32'h2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_rst_pulses", pulses(), 32'h0);
      chk("mr_rst_busy", {31'd0, flush_busy_o}, 32'd0);
      chk("mr_rst_ready", {31'd0, resp_ready}, 32'd1);
      chk("mr_rst_set", {27'd0, update_set_o}, 32'd0);
      for (int i = 0; i < 40; i++) begin
         step();
         chk("mr_quiet_pulses", pulses(), 32'h0);
         chk("mr_quiet_busy", {31'd0, flush_busy_o}, 32'd0);
      end
      chk("mr_ready_end", {31'd0, resp_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
